// File: rtl/quick_spi_slave.sv
// SPI slave: receives an INCOMING_DATA_WIDTH word, waits GAP_BITS bit periods, then returns tx_data.
// Define QUICK_SPI_SLAVE_FRAME_ERR_EN to pulse frame_error when a frame is aborted by ss_n.
module quick_spi_slave #(
  parameter int INCOMING_DATA_WIDTH = 16,
  parameter int OUTGOING_DATA_WIDTH = 8,
  parameter int CPOL                = 0,
  parameter int CPHA                = 0,
  parameter int GAP_BITS            = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [OUTGOING_DATA_WIDTH-1:0] tx_data,
  output logic [INCOMING_DATA_WIDTH-1:0] rx_data,
  output logic                           rx_valid,
  output logic                           tx_done,
  output logic                           busy,
  output logic                           frame_error,
  input  logic                           sclk,
  input  logic                           ss_n,
  input  logic                           mosi,
  output logic                           miso
);

  localparam logic IDLE_CLK = (CPOL != 0);
  localparam int   MAX_IO   = (INCOMING_DATA_WIDTH > OUTGOING_DATA_WIDTH) ?
                              INCOMING_DATA_WIDTH : OUTGOING_DATA_WIDTH;
  localparam int   MAX_W    = (MAX_IO > GAP_BITS) ? MAX_IO : GAP_BITS;
  localparam int   CNT_W    = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] LAST_RX  = CNT_W'(INCOMING_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_TX  = CNT_W'(OUTGOING_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {IDLE, RECEIVE, GAP, TRANSMIT, DONE} state_t;

  logic sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
  logic ss_meta_reg, ss_sync_reg, ss_prev_reg;
  logic mosi_meta_reg, mosi_sync_reg;
  logic [1:0] fill_reg;
  logic armed_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_meta_reg <= IDLE_CLK;
      sclk_sync_reg <= IDLE_CLK;
      sclk_prev_reg <= IDLE_CLK;
      ss_meta_reg   <= 1'b1;
      ss_sync_reg   <= 1'b1;
      ss_prev_reg   <= 1'b1;
      mosi_meta_reg <= 1'b0;
      mosi_sync_reg <= 1'b0;
      fill_reg      <= 2'd0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_meta_reg <= sclk;
      sclk_sync_reg <= sclk_meta_reg;
      sclk_prev_reg <= sclk_sync_reg;
      ss_meta_reg   <= ss_n;
      ss_sync_reg   <= ss_meta_reg;
      ss_prev_reg   <= ss_sync_reg;
      mosi_meta_reg <= mosi;
      mosi_sync_reg <= mosi_meta_reg;
      if (fill_reg != 2'd2)
        fill_reg <= fill_reg + 2'd1;
      // Start frames only after ss_n has really been seen high, so a low ss_n
      // held across reset is not mistaken for a new frame.
      if (fill_reg == 2'd2 && ss_sync_reg)
        armed_reg <= 1'b1;
    end
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;
  assign lead_edge   = (sclk_prev_reg == IDLE_CLK) && (sclk_sync_reg != IDLE_CLK);
  assign trail_edge  = (sclk_prev_reg != IDLE_CLK) && (sclk_sync_reg == IDLE_CLK);
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign ss_fall     = ss_prev_reg & ~ss_sync_reg;
  assign ss_rise     = ~ss_prev_reg & ss_sync_reg;

  state_t                         state_reg, state_next;
  logic [CNT_W-1:0]               cnt_reg, cnt_next;
  logic [INCOMING_DATA_WIDTH-1:0] rx_buf_reg, rx_buf_next;
  logic [INCOMING_DATA_WIDTH-1:0] rx_data_reg, rx_data_next;
  logic                           rx_valid_reg, rx_valid_next;
  logic [OUTGOING_DATA_WIDTH-1:0] tx_buf_reg, tx_buf_next;
  logic                           miso_bit_reg, miso_bit_next;
  logic                           drive_reg, drive_next;
  logic                           tx_done_reg, tx_done_next;
  logic                           abort, enter_tx;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rx_buf_next   = rx_buf_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    tx_buf_next   = tx_buf_reg;
    miso_bit_next = miso_bit_reg;
    drive_next    = drive_reg;
    tx_done_next  = 1'b0;
    abort         = 1'b0;
    enter_tx      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall && armed_reg && enable) begin
          state_next  = RECEIVE;
          tx_buf_next = tx_data;
          rx_buf_next = '0;
          cnt_next    = '0;
        end
      end
      RECEIVE: begin
        if (ss_rise) begin
          abort = 1'b1;
        end else if (sample_edge) begin
          rx_buf_next = {rx_buf_reg[INCOMING_DATA_WIDTH-2:0], mosi_sync_reg};
          if (cnt_reg == LAST_RX) begin
            rx_data_next  = rx_buf_next;
            rx_valid_next = 1'b1;
            cnt_next      = '0;
            if (GAP_BITS == 0)
              enter_tx = 1'b1;
            else
              state_next = GAP;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      GAP: begin
        if (ss_rise) begin
          abort = 1'b1;
        end else if (sample_edge) begin
          if (cnt_reg == LAST_GAP)
            enter_tx = 1'b1;
          else
            cnt_next = cnt_reg + 1'b1;
        end
      end
      TRANSMIT: begin
        if (ss_rise) begin
          abort = 1'b1;
        end else begin
          // tx_buf_reg advances on sample edges, so a shift edge always
          // presents the bit the master samples next.
          if (shift_edge) begin
            miso_bit_next = tx_buf_reg[OUTGOING_DATA_WIDTH-1];
            drive_next    = 1'b1;
          end
          if (sample_edge) begin
            tx_buf_next = tx_buf_reg << 1;
            if (cnt_reg == LAST_TX) begin
              tx_done_next = 1'b1;
              drive_next   = 1'b0;
              cnt_next     = '0;
              state_next   = DONE;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
      end
      DONE: begin
        drive_next = 1'b0;
        if (ss_rise)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (enter_tx) begin
      state_next    = TRANSMIT;
      cnt_next      = '0;
      drive_next    = (CPHA == 0);
      miso_bit_next = tx_buf_reg[OUTGOING_DATA_WIDTH-1];
    end
    if (abort) begin
      state_next = IDLE;
      drive_next = 1'b0;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rx_buf_reg   <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      tx_buf_reg   <= '0;
      miso_bit_reg <= 1'b0;
      drive_reg    <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rx_buf_reg   <= rx_buf_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      tx_buf_reg   <= tx_buf_next;
      miso_bit_reg <= miso_bit_next;
      drive_reg    <= drive_next;
      tx_done_reg  <= tx_done_next;
    end
  end

`ifdef QUICK_SPI_SLAVE_FRAME_ERR_EN
  logic frame_error_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_error_reg <= 1'b0;
    else
      frame_error_reg <= abort;
  end
  assign frame_error = frame_error_reg;
`else
  assign frame_error = 1'b0;
`endif

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign tx_done  = tx_done_reg;
  assign busy     = (state_reg != IDLE);
  assign miso     = drive_reg ? miso_bit_reg : 1'bz;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench for quick_spi_slave: one instance per SPI mode, a bit-banged master, pulse monitors.
module tb_quick_spi_slave;

  localparam int H = 8;  // sclk half period in clk cycles
`ifdef QUICK_SPI_SLAVE_FRAME_ERR_EN
  localparam int FE_EXP = 1;
`else
  localparam int FE_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        mosi = 1'b0;
  logic [3:0]  sclk_pin = 4'b1100;
  logic [3:0]  ss_pin = 4'b1111;
  logic [15:0] rx_data_w [4];
  logic [3:0]  rx_valid_w, tx_done_w, busy_w, fe_w, miso_z, miso_v;

  int rxv_cnt [4] = '{default: 0};
  int txd_cnt [4] = '{default: 0};
  int fe_cnt [4] = '{default: 0};
  int busy_cnt [4] = '{default: 0};
  int drv_cnt [4] = '{default: 0};
  int s_rxv, s_txd, s_fe, s_busy, s_drv;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    wire miso_c;
    quick_spi_slave #(
      .INCOMING_DATA_WIDTH(16), .OUTGOING_DATA_WIDTH(8),
      .CPOL(gi / 2), .CPHA(gi % 2), .GAP_BITS(2)
    ) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .tx_data(tx_data),
      .rx_data(rx_data_w[gi]), .rx_valid(rx_valid_w[gi]), .tx_done(tx_done_w[gi]),
      .busy(busy_w[gi]), .frame_error(fe_w[gi]),
      .sclk(sclk_pin[gi]), .ss_n(ss_pin[gi]), .mosi(mosi), .miso(miso_c)
    );
    assign miso_z[gi] = (miso_c === 1'bz);
    assign miso_v[gi] = miso_c;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid_w[i]) rxv_cnt[i] <= rxv_cnt[i] + 1;
      if (tx_done_w[i])  txd_cnt[i] <= txd_cnt[i] + 1;
      if (fe_w[i])       fe_cnt[i] <= fe_cnt[i] + 1;
      if (busy_w[i])     busy_cnt[i] <= busy_cnt[i] + 1;
      if (!miso_z[i])    drv_cnt[i] <= drv_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int m);
    s_rxv = rxv_cnt[m]; s_txd = txd_cnt[m]; s_fe = fe_cnt[m];
    s_busy = busy_cnt[m]; s_drv = drv_cnt[m];
  endtask

  task automatic wait_h();
    repeat (H) @(posedge clk);
    #1;
  endtask

  // Clocks nbits bit periods on instance m; reply collects the bits sampled after 16+2.
  task automatic frame(input int m, input logic [15:0] word, input int nbits, input int rst_at,
                       input int post, output logic [7:0] reply, output int nz, output logic z_end);
    logic cpha;
    logic b;
    cpha  = (m % 2) != 0;
    reply = 8'h00;
    nz    = 0;
    @(posedge clk); #1;
    ss_pin[m] = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? word[15 - i] : 1'b0;
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end
      if (!cpha) mosi = b;
      wait_h();
      if (!cpha) begin
        if (i < 18) nz += miso_z[m] ? 0 : 1;
        else        reply = {reply[6:0], miso_v[m]};
      end
      sclk_pin[m] = ~sclk_pin[m];
      if (cpha) mosi = b;
      wait_h();
      if (cpha) begin
        if (i < 18) nz += miso_z[m] ? 0 : 1;
        else        reply = {reply[6:0], miso_v[m]};
      end
      sclk_pin[m] = ~sclk_pin[m];
    end
    wait_h();
    z_end = miso_z[m];
    ss_pin[m] = 1'b1;
    repeat (post) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rep;
    int nz;
    logic ze;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data_w[0], 16'h0000);
    check("rst_rx_valid", rx_valid_w[0], 1'b0);
    check("rst_tx_done", tx_done_w[0], 1'b0);
    check("rst_busy", busy_w[0], 1'b0);
    check("rst_frame_error", fe_w[0], 1'b0);
    check("rst_miso_z", miso_z[0], 1'b1);
    check("rst_miso_z_m3", miso_z[3], 1'b1);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    tx_data = 8'h3C;
    snap(0);
    frame(0, 16'hA55A, 26, -1, 20, rep, nz, ze);
    $display("frame mode0 A55A: rx_data=%h reply=%h", rx_data_w[0], rep);
    check("m0_rx_data", rx_data_w[0], 16'hA55A);
    check("m0_reply", rep, 8'h3C);
    check("m0_rx_valid_pulses", rxv_cnt[0] - s_rxv, 1);
    check("m0_tx_done_pulses", txd_cnt[0] - s_txd, 1);
    check("m0_frame_error_pulses", fe_cnt[0] - s_fe, 0);
    check("m0_miso_z_before_tx", nz, 0);
    check("m0_miso_z_done", ze, 1'b1);
    check("m0_busy_after", busy_w[0], 1'b0);

    tx_data = 8'h80;
    for (int m = 1; m < 4; m++) begin
      snap(m);
      frame(m, 16'h0001, 26, -1, 20, rep, nz, ze);
      $display("frame mode%0d 0001: rx_data=%h reply=%h", m, rx_data_w[m], rep);
      check("mx_rx_data", rx_data_w[m], 16'h0001);
      check("mx_reply", rep, 8'h80);
      check("mx_rx_valid_pulses", rxv_cnt[m] - s_rxv, 1);
      check("mx_tx_done_pulses", txd_cnt[m] - s_txd, 1);
      check("mx_miso_z_before_tx", nz, 0);
      check("mx_miso_z_done", ze, 1'b1);
      check("mx_miso_z_idle", miso_z[m], 1'b1);
    end

    snap(0);
    frame(0, 16'hFFFF, 7, -1, 20, rep, nz, ze);
    $display("frame mode0 aborted after 7 bits: rx_data=%h", rx_data_w[0]);
    check("abort_rx_data", rx_data_w[0], 16'hA55A);
    check("abort_rx_valid_pulses", rxv_cnt[0] - s_rxv, 0);
    check("abort_tx_done_pulses", txd_cnt[0] - s_txd, 0);
    check("abort_frame_error_pulses", fe_cnt[0] - s_fe, FE_EXP);
    check("abort_busy", busy_w[0], 1'b0);

    enable = 1'b0;
    snap(0);
    frame(0, 16'h5555, 26, -1, 20, rep, nz, ze);
    $display("frame mode0 enable=0: rx_data=%h", rx_data_w[0]);
    check("dis_rx_valid_pulses", rxv_cnt[0] - s_rxv, 0);
    check("dis_tx_done_pulses", txd_cnt[0] - s_txd, 0);
    check("dis_frame_error_pulses", fe_cnt[0] - s_fe, 0);
    check("dis_busy_cycles", busy_cnt[0] - s_busy, 0);
    check("dis_miso_drive_cycles", drv_cnt[0] - s_drv, 0);
    check("dis_rx_data", rx_data_w[0], 16'hA55A);
    enable = 1'b1;

    snap(0);
    frame(0, 16'hBEEF, 26, 10, 20, rep, nz, ze);
    $display("frame mode0 reset at bit 10: rx_data=%h", rx_data_w[0]);
    check("rstmid_rx_data", rx_data_w[0], 16'h0000);
    check("rstmid_rx_valid_pulses", rxv_cnt[0] - s_rxv, 0);
    check("rstmid_tx_done_pulses", txd_cnt[0] - s_txd, 0);
    tx_data = 8'hC3;
    snap(0);
    frame(0, 16'h1234, 26, -1, 20, rep, nz, ze);
    $display("frame mode0 1234 after reset: rx_data=%h reply=%h", rx_data_w[0], rep);
    check("rstnew_rx_data", rx_data_w[0], 16'h1234);
    check("rstnew_reply", rep, 8'hC3);
    check("rstnew_rx_valid_pulses", rxv_cnt[0] - s_rxv, 1);

    tx_data = 8'hA5;
    snap(0);
    frame(0, 16'hFFFF, 26, -1, 2, rep, nz, ze);
    $display("frame mode0 FFFF back-to-back: rx_data=%h reply=%h", rx_data_w[0], rep);
    check("b2b1_rx_data", rx_data_w[0], 16'hFFFF);
    check("b2b1_reply", rep, 8'hA5);
    tx_data = 8'h5A;
    frame(0, 16'h0000, 26, -1, 20, rep, nz, ze);
    $display("frame mode0 0000 back-to-back: rx_data=%h reply=%h", rx_data_w[0], rep);
    check("b2b2_rx_data", rx_data_w[0], 16'h0000);
    check("b2b2_reply", rep, 8'h5A);
    check("b2b_rx_valid_pulses", rxv_cnt[0] - s_rxv, 2);
    check("b2b_tx_done_pulses", txd_cnt[0] - s_txd, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quick_spi_slave.md
QUICK_SPI_SLAVE -- requirements
Module: quick_spi_slave

Interface
REQ-001 SHALL have parameter INCOMING_DATA_WIDTH, default 16, bits received from master on mosi per frame.
REQ-002 SHALL have parameter OUTGOING_DATA_WIDTH, default 8, bits returned to master on miso per frame.
REQ-003 SHALL have parameters CPOL, default 0, and CPHA, default 0, SPI mode matching the master.
REQ-004 SHALL have parameter GAP_BITS, default 2, idle bit periods between last received bit and first transmitted bit.
REQ-005 SHALL have ports: clk input 1 system clock; reset input 1 asynchronous active-high reset.
REQ-006 SHALL have ports: enable input 1 accept frames; tx_data input OUTGOING_DATA_WIDTH reply word.
REQ-007 SHALL have ports: rx_data output INCOMING_DATA_WIDTH last received word; rx_valid output 1 one-cycle pulse on rx_data update.
REQ-008 SHALL have ports: tx_done output 1 one-cycle pulse after last miso bit; busy output 1 high while ss_n low and frame accepted; frame_error output 1 one-cycle pulse.
REQ-009 SHALL have ports: sclk input 1, ss_n input 1, mosi input 1 (SPI bus, asynchronous to clk); miso output 1 (high-Z when not driving).

Function
REQ-010 sclk, ss_n, mosi SHALL pass through 2-flop synchronizers in clk; edges detected on synchronized values; clk SHALL be >= 8x sclk.
REQ-011 Sample edge = leading edge (sclk leaves CPOL) if CPHA=0, trailing edge otherwise; shift edge = the other edge.
REQ-012 States: IDLE, RECEIVE, GAP, TRANSMIT, DONE.
REQ-013 IDLE -> RECEIVE on synchronized ss_n falling edge with enable=1; tx_data captured into shift buffer same cycle; busy=1; bit counter cleared.
REQ-014 ss_n falling with enable=0: frame ignored, miso stays high-Z, no outputs pulse.
REQ-015 RECEIVE: each sample edge shifts mosi into receive buffer MSB-first; after INCOMING_DATA_WIDTH samples, rx_data <= buffer, rx_valid=1 for one cycle, -> GAP.
REQ-016 GAP: counts GAP_BITS sample edges with miso high-Z, then -> TRANSMIT; GAP_BITS=0 goes directly to TRANSMIT.
REQ-017 TRANSMIT: miso driven from buffer MSB on entry (CPHA=0) or on first shift edge (CPHA=1), next bit on each later shift edge; after OUTGOING_DATA_WIDTH sample edges, tx_done=1 one cycle, -> DONE.
REQ-018 DONE: miso high-Z; ignores sclk edges; -> IDLE on ss_n rising.
REQ-019 ss_n rising in any state other than IDLE/DONE: abort, miso high-Z, rx_data unchanged, -> IDLE, busy=0 next cycle.
REQ-020 Simultaneous ss_n rising and final sample edge in RECEIVE: abort wins, no rx_valid.
REQ-021 busy SHALL be 0 in IDLE, 1 in all other states.
REQ-022 Extra sclk edges beyond frame length SHALL be ignored.

Reset
REQ-023 On reset=1: state IDLE, rx_data=0, rx_valid=0, tx_done=0, busy=0, frame_error=0, miso high-Z, buffers and counters 0, synchronizer flops to ss_n=1, sclk=CPOL, mosi=0.
REQ-024 Reset asserted mid-frame SHALL abort immediately; after release the slave waits for a new ss_n falling edge (current low ss_n not treated as a start).

Configuration
REQ-025 Macro QUICK_SPI_SLAVE_FRAME_ERR_EN defined: abort per REQ-019 from RECEIVE, GAP or TRANSMIT pulses frame_error for one cycle.
REQ-026 Macro undefined: frame_error tied 0; aborts silent; all other behaviour identical.

Verification
REQ-027 Mode 0, master sends 16'hA55A, tx_data=8'h3C, GAP_BITS=2 -> rx_data=16'hA55A with one rx_valid pulse; master reads 8'h3C; one tx_done.
REQ-028 Modes 1,2,3 with 16'h0001/8'h80 -> same data correct each mode; miso high-Z outside TRANSMIT.
REQ-029 ss_n raised after 7 bits -> no rx_valid, rx_data unchanged, frame_error pulse only with macro defined.
REQ-030 enable=0 whole frame -> no pulses, miso high-Z, busy=0.
REQ-031 reset pulse at bit 10 of 16, then full frame 16'h1234 -> rx_data=16'h1234 only after the new frame.
REQ-032 Two back-to-back frames 16'hFFFF then 16'h0000 with 2 clk idle on ss_n -> two rx_valid pulses, correct values.
